// File: rtl/commit_trace_writer.sv
// commit_trace_writer: packs each retired instruction into a four-word trace
// record, buffers records in a FIFO and serializes them as 32-bit words over a
// valid/ready stream. Records arriving while the FIFO is full are dropped and
// counted.
module commit_trace_writer #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     trace_en,
    input  logic                     commit_valid,
    input  logic [35:0]              commit_pc,
    input  logic [31:0]              commit_inst,
    input  logic                     commit_wb_en,
    input  logic [4:0]               commit_wb_reg,
    input  logic [35:0]              commit_wb_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_data,
    output logic                     out_last,
    output logic                     overflow,
    output logic [15:0]              drop_count,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_W0,
        S_W1,
        S_W2,
        S_W3
    } state_t;

    state_t         state;
    logic [127:0]   mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [127:0]   hold;
    logic [7:0]     seq;

    logic           commit_fire;
    logic           push;
    logic           pop;
    logic           head_avail;
    logic [4:0]     wb_reg_m;
    logic [35:0]    wb_data_m;
    logic [127:0]   rec;

    // Record assembly; word 0 sits in the low 32 bits, word 3 in the high 32.
    always_comb begin
        wb_reg_m  = commit_wb_en ? commit_wb_reg  : '0;
        wb_data_m = commit_wb_en ? commit_wb_data : '0;
        rec = {wb_data_m[31:0],
               commit_inst,
               commit_pc[31:0],
               8'hA5, seq, commit_wb_en, wb_reg_m, 2'b00,
               wb_data_m[35:32], commit_pc[35:32]};
    end

    // Push/pop decisions; fullness is judged on the pre-edge count so a
    // same-cycle pop never makes room for a push.
    always_comb begin
        commit_fire = trace_en && commit_valid;
        push        = commit_fire && (fifo_count < DEPTH_C);
        head_avail  = (fifo_count != '0);
        pop         = head_avail &&
                      ((state == S_IDLE) || ((state == S_W3) && out_ready));
    end

    // Record storage; contents need no reset since pointers gate every read.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= rec;
    end

    // FIFO pointers, occupancy, sequence counter and drop accounting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            seq        <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            fifo_count <= fifo_count + (AW + 1)'(push) - (AW + 1)'(pop);
            if (commit_fire)
                seq <= seq + 8'd1;
            if (commit_fire && !push) begin
                overflow <= 1'b1;
                if (drop_count != 16'hFFFF)
                    drop_count <= drop_count + 16'd1;
            end
        end
    end

    // Serializer FSM: loads the head record into the holding register and
    // steps through its four words on each accepted handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            hold  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        hold  <= mem[rd_ptr];
                        state <= S_W0;
                    end
                end
                S_W0: if (out_ready) state <= S_W1;
                S_W1: if (out_ready) state <= S_W2;
                S_W2: if (out_ready) state <= S_W3;
                S_W3: begin
                    if (out_ready) begin
                        if (pop) begin
                            hold  <= mem[rd_ptr];
                            state <= S_W0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Output word selection from the holding register; zero while idle.
    always_comb begin
        out_valid = (state != S_IDLE);
        out_last  = (state == S_W3);
        case (state)
            S_W0:    out_data = hold[31:0];
            S_W1:    out_data = hold[63:32];
            S_W2:    out_data = hold[95:64];
            S_W3:    out_data = hold[127:96];
            default: out_data = '0;
        endcase
    end

endmodule

// File: tb/tb_commit_trace_writer.sv
// tb_commit_trace_writer: directed table-driven checks of commit_trace_writer
// plus hand-written sequences for overflow, stalls, seq wrap and reset.
module tb_commit_trace_writer;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        trace_en = 1'b1;
    logic        commit_valid = 1'b0;
    logic [35:0] commit_pc = '0;
    logic [31:0] commit_inst = '0;
    logic        commit_wb_en = 1'b0;
    logic [4:0]  commit_wb_reg = '0;
    logic [35:0] commit_wb_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic        out_last;
    logic        overflow;
    logic [15:0] drop_count;
    logic [$clog2(DEPTH):0] fifo_count;

    int n_checks = 0;
    int n_fail   = 0;

    commit_trace_writer #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .trace_en       (trace_en),
        .commit_valid   (commit_valid),
        .commit_pc      (commit_pc),
        .commit_inst    (commit_inst),
        .commit_wb_en   (commit_wb_en),
        .commit_wb_reg  (commit_wb_reg),
        .commit_wb_data (commit_wb_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_last       (out_last),
        .overflow       (overflow),
        .drop_count     (drop_count),
        .fifo_count     (fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [35:0]      pc;
        logic [31:0]      inst;
        logic             wb_en;
        logic [4:0]       wb_reg;
        logic [35:0]      wb_data;
        logic [3:0][31:0] w;
    } vec_t;

    vec_t vecs [4];

    function automatic vec_t mkvec(input logic [35:0] pc, input logic [31:0] inst,
                                   input logic wb_en, input logic [4:0] wb_reg,
                                   input logic [35:0] wb_data,
                                   input logic [31:0] w0, input logic [31:0] w1,
                                   input logic [31:0] w2, input logic [31:0] w3);
        vec_t v;
        v.pc = pc; v.inst = inst; v.wb_en = wb_en; v.wb_reg = wb_reg;
        v.wb_data = wb_data;
        v.w = {w3, w2, w1, w0};
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [35:0] pc, input logic [31:0] inst,
                         input logic wb_en, input logic [4:0] wb_reg,
                         input logic [35:0] wb_data);
        commit_valid   = 1'b1;
        commit_pc      = pc;
        commit_inst    = inst;
        commit_wb_en   = wb_en;
        commit_wb_reg  = wb_reg;
        commit_wb_data = wb_data;
    endtask

    task automatic do_reset();
        @(negedge clk);
        commit_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        vecs[0] = mkvec(36'h1_0000_0040, 32'h1234_5678, 1'b1, 5'd3,  36'hF_0000_0007,
                        32'hA500_8CF1, 32'h0000_0040, 32'h1234_5678, 32'h0000_0007);
        vecs[1] = mkvec(36'h0_8000_0000, 32'h0000_0013, 1'b0, 5'd5,  36'h3_DEAD_BEEF,
                        32'hA501_0000, 32'h8000_0000, 32'h0000_0013, 32'h0000_0000);
        vecs[2] = mkvec(36'hA_FFFF_FFFC, 32'hFFFF_FFFF, 1'b1, 5'd31, 36'h5_0000_0001,
                        32'hA502_FC5A, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'h0000_0001);
        vecs[3] = mkvec(36'h0_0000_1000, 32'h0040_0093, 1'b1, 5'd16, 36'h0_1234_ABCD,
                        32'hA503_C000, 32'h0000_1000, 32'h0040_0093, 32'h1234_ABCD);

        // Reset state
        #2;
        chk("rst_valid", out_valid, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_drop", drop_count, 0);
        chk("rst_data", out_data, 0);
        @(negedge clk);
        rst = 1'b0;

        // Table: one commit each, minimum latency and word order
        for (int i = 0; i < 4; i++) begin
            out_ready = 1'b1;
            drive(vecs[i].pc, vecs[i].inst, vecs[i].wb_en, vecs[i].wb_reg, vecs[i].wb_data);
            @(negedge clk);
            commit_valid = 1'b0;
            chk("lat_idle_valid", out_valid, 0);
            chk("lat_idle_data", out_data, 0);
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                chk("vec_valid", out_valid, 1);
                chk($sformatf("vec%0d_w%0d", i, k), out_data, vecs[i].w[k]);
                chk("vec_last", out_last, (k == 3) ? 1 : 0);
            end
            @(negedge clk);
            chk("vec_end_valid", out_valid, 0);
            chk("vec_end_last", out_last, 0);
        end

        // Overflow: DEPTH+2 back-to-back commits with consumer stalled
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            drive(36'(i), 32'h0, 1'b0, 5'd0, 36'h0);
            @(negedge clk);
            chk("ovf_count", fifo_count, (i == 0) ? 1 : ((i < DEPTH) ? i : DEPTH));
        end
        commit_valid = 1'b0;
        chk("ovf_flag", overflow, 1);
        chk("ovf_drop", drop_count, 1);
        chk("ovf_w0_rec0", out_data, 32'hA500_0000);
        out_ready = 1'b1;
        for (int r = 0; r <= DEPTH; r++) begin
            for (int k = 0; k < 4; k++) begin
                chk("drain_valid", out_valid, 1);
                if (k == 0)
                    chk($sformatf("drain_seq_r%0d", r), out_data, 32'hA500_0000 | (32'(r) << 16));
                if (k == 1)
                    chk("drain_pc", out_data, r);
                @(negedge clk);
            end
        end
        chk("drain_idle", out_valid, 0);
        chk("drain_count", fifo_count, 0);
        drive(36'h0, 32'h0, 1'b0, 5'd0, 36'h0);
        @(negedge clk);
        commit_valid = 1'b0;
        @(negedge clk);
        chk("seq_skip_drop", out_data, 32'hA500_0000 | (32'(DEPTH + 2) << 16));
        repeat (4) @(negedge clk);

        // Stall pattern during a record
        do_reset();
        out_ready = 1'b0;
        drive(vecs[0].pc, vecs[0].inst, vecs[0].wb_en, vecs[0].wb_reg, vecs[0].wb_data);
        @(negedge clk);
        commit_valid = 1'b0;
        @(negedge clk);
        begin
            bit pat [7] = '{1, 0, 0, 1, 1, 0, 1};
            int idx = 0;
            for (int c = 0; c < 7; c++) begin
                chk("stall_valid", out_valid, 1);
                chk($sformatf("stall_c%0d", c), out_data, vecs[0].w[idx]);
                chk("stall_last", out_last, (idx == 3) ? 1 : 0);
                out_ready = pat[c];
                @(negedge clk);
                if (pat[c]) idx++;
            end
            chk("stall_words", idx, 4);
            chk("stall_end", out_valid, 0);
        end
        out_ready = 1'b1;

        // Sequence wrap and trace_en gating
        do_reset();
        for (int i = 0; i < 256; i++) begin
            drive(36'(i), 32'h0, 1'b0, 5'd0, 36'h0);
            @(negedge clk);
            commit_valid = 1'b0;
            repeat (3) @(negedge clk);
        end
        repeat (8) @(negedge clk);
        chk("wrap_drop", drop_count, 0);
        chk("wrap_idle", out_valid, 0);
        trace_en = 1'b0;
        drive(36'h7, 32'h0, 1'b0, 5'd0, 36'h0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("te0_valid", out_valid, 0);
            chk("te0_count", fifo_count, 0);
        end
        trace_en = 1'b1;
        drive(36'h0, 32'h0, 1'b0, 5'd0, 36'h0);
        @(negedge clk);
        commit_valid = 1'b0;
        @(negedge clk);
        chk("wrap_seq0", out_data, 32'hA500_0000);
        repeat (4) @(negedge clk);

        // Asynchronous reset during W2 with a record queued
        do_reset();
        drive(vecs[2].pc, vecs[2].inst, vecs[2].wb_en, vecs[2].wb_reg, vecs[2].wb_data);
        @(negedge clk);
        commit_valid = 1'b0;
        @(negedge clk);
        drive(vecs[3].pc, vecs[3].inst, vecs[3].wb_en, vecs[3].wb_reg, vecs[3].wb_data);
        @(negedge clk);
        commit_valid = 1'b0;
        @(negedge clk);
        chk("mid_w2", out_data, vecs[2].w[2]);
        chk("mid_count", fifo_count, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_count", fifo_count, 0);
        chk("arst_data", out_data, 0);
        @(negedge clk);
        rst = 1'b0;
        drive(vecs[0].pc, vecs[0].inst, vecs[0].wb_en, vecs[0].wb_reg, vecs[0].wb_data);
        @(negedge clk);
        commit_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_w0", out_data, 32'hA500_8CF1);
        chk("post_rst_valid", out_valid, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
